vscale_mem_arbiter: RTL and testbench
=====================================

# vscale_mem_arbiter

Shares a single external memory port between the vscale instruction-fetch and data-memory requesters. It accepts one transaction at a time from either side and forwards it to the shared port. It returns the response, or an error, to the side that issued it. It sits between the core pipeline (imem/dmem request logic) and the memory system. It supplies the `imem_badmem_e`/`dmem_badmem_e` conditions consumed by pipeline control.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, data word width
- `TIMEOUT_CYCLES`, 255, maximum cycles waited for a memory response before an error is reported (1..65535)
- `clk` in 1 — clock, all state on rising edge
- `reset` in 1 — asynchronous, active-low reset
- `imem_req_valid` in 1 — fetch request
- `imem_req_ready` out 1 — fetch request accepted this cycle
- `imem_req_addr` in ADDR_WIDTH — fetch address
- `imem_resp_valid` out 1 — fetch response pulse
- `imem_resp_rdata` out DATA_WIDTH — fetched word
- `imem_badmem_e` out 1 — fetch error, qualified by `imem_resp_valid`
- `dmem_req_valid` in 1 — data request
- `dmem_req_ready` out 1 — data request accepted this cycle
- `dmem_req_addr` in ADDR_WIDTH — data address
- `dmem_req_wen` in 1 — 1 = store
- `dmem_req_size` in 3 — 0 = byte, 1 = half, 2 = word; others illegal
- `dmem_req_wdata` in DATA_WIDTH — store data
- `dmem_resp_valid` out 1 — data response pulse
- `dmem_resp_rdata` out DATA_WIDTH — load data
- `dmem_badmem_e` out 1 — data error, qualified by `dmem_resp_valid`
- `mem_req_valid` out 1, `mem_req_ready` in 1 — shared port request handshake
- `mem_req_addr` out ADDR_WIDTH, `mem_req_wen` out 1, `mem_req_size` out 3, `mem_req_wdata` out DATA_WIDTH — registered request fields
- `mem_resp_valid` in 1, `mem_resp_rdata` in DATA_WIDTH, `mem_resp_err` in 1 — shared port response

## Operation
- States are IDLE, REQ, RESP, ERR, DRAIN. There is one outstanding transaction at most.
- **IDLE**
  - Arbitrate only in this state.
  - If only one side is valid, grant that side.
  - If both sides are valid, grant the side not granted last (`last_grant` flop; reset value = imem, so dmem wins the first tie).
  - `*_req_ready` is combinational and asserted only for the granted side in IDLE.
  - On grant, register addr/wen/size/wdata and owner.
  - A fetch always uses size 2 and wen 0.
- **Misaligned or illegal dmem request**
  - Applies when size = 1 with addr[0] set, size = 2 with addr[1:0] ≠ 0, or size > 2.
  - Still accepted (ready = 1), then go to ERR. No memory transaction is issued.
- **Fetch alignment**
  - A fetch with addr[1:0] ≠ 0 also goes to ERR.
- **REQ**
  - `mem_req_valid` = 1 with the registered fields held stable.
  - On `mem_req_ready`, go to RESP and clear the timeout counter.
- **RESP**
  - Waits for `mem_resp_valid`.
  - Response forwarded combinationally to the owner: `*_resp_valid` = 1, rdata = `mem_resp_rdata`, `*_badmem_e` = `mem_resp_err`. Then go to IDLE.
  - Counter increments each cycle without a response. When it reaches TIMEOUT_CYCLES:
    - pulse owner `*_resp_valid` with `*_badmem_e` = 1 and rdata = 0;
    - go to DRAIN.
- **ERR**
  - One cycle: owner `*_resp_valid` = 1, `*_badmem_e` = 1, rdata = 0. Then go to IDLE.
- **DRAIN**
  - Wait for `mem_resp_valid`, discard it, then go to IDLE.
  - No request is accepted until the drain completes.
- The non-owner never sees `*_resp_valid`.
- A requester may drop `*_req_valid` before ready without effect. Once accepted, the transaction completes regardless.

## Timing
- Reset (asynchronous assert, synchronous-release-safe) puts the block in IDLE. At reset, all outputs are 0 except `*_req_ready`, which follows IDLE arbitration. Registered fields, counter and `last_grant` = imem.
- Reset mid-transaction abandons the transaction. The external memory must be reset alongside.
- Minimum latency:
  - accept at cycle 0;
  - `mem_req_valid` at cycle 1 (ready in the same cycle);
  - response at cycle 2 at earliest, forwarded in that cycle;
  - next accept at cycle 3.
- ERR path: response in cycle 1, next accept in cycle 2.
- Timeout fires exactly TIMEOUT_CYCLES cycles after RESP entry when no response arrives.
- If `mem_resp_valid` arrives in the same cycle the counter hits its limit, the real response wins and the block goes to IDLE.

## Structure
- Shared package/header `vscale_mem_arb_constants.vh` holds:
  - state encodings (3 bits);
  - owner encoding;
  - size codes reusing the existing memory-size macros.
- One natural sub-module: `vscale_mem_arb_timeout`. It is a loadable, saturating down-counter with a `clear`/`en`/`expired` interface.
- The remainder is a single FSM plus request registers.

## Test plan
- **Single fetch.** imem addr 0x100 and memory ready immediately, data 0xDEADBEEF at cycle 2 -> `imem_resp_valid` at cycle 2 with rdata 0xDEADBEEF, `imem_badmem_e` = 0, `mem_req_wen` = 0, size 2.
- **Tie round-robin.** Both sides valid continuously from reset -> grants in order dmem, imem, dmem, imem; no response goes to the non-owner.
- **Misaligned store.** dmem store with addr 0x203 and size 1 -> `dmem_resp_valid` plus `dmem_badmem_e` one cycle after accept; `mem_req_valid` never asserted.
- **Timeout.** TIMEOUT_CYCLES = 4, memory accepts but never responds -> error response 4 cycles after RESP entry. A late `mem_resp_valid` 10 cycles later is discarded, and the next request is accepted only afterwards.
- **Memory error.** Load to 0x300 answered with `mem_resp_err` = 1 -> `dmem_badmem_e` = 1 in the response cycle.
- **Reset mid-transaction.** Reset asserted while in REQ -> `mem_req_valid` drops asynchronously, state is IDLE, and the next imem request is granted normally after release.

Source files
------------

// File: rtl/vscale_mem_arbiter_pkg.sv
// Shared encodings for the vscale imem/dmem memory arbiter: FSM states, owner ids,
// memory size codes and the dmem alignment rule.
package vscale_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RESP  = 3'd2,
    ST_ERR   = 3'd3,
    ST_DRAIN = 3'd4
  } arb_state_e;

  typedef enum logic {
    OWNER_IMEM = 1'b0,
    OWNER_DMEM = 1'b1
  } owner_e;

  localparam logic [2:0] MEM_SIZE_BYTE = 3'd0;
  localparam logic [2:0] MEM_SIZE_HALF = 3'd1;
  localparam logic [2:0] MEM_SIZE_WORD = 3'd2;

  localparam int TMO_W = 16;

  // Size codes above word are illegal and are reported the same way as misalignment.
  function automatic logic dmem_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      MEM_SIZE_BYTE: bad = 1'b0;
      MEM_SIZE_HALF: bad = addr_lo[0];
      MEM_SIZE_WORD: bad = (addr_lo != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/vscale_mem_arbiter_if.sv
// Request/response bundle between the fetch side, the data side and the shared memory port.
// slave is the arbiter's view; master is the view of the cores plus memory around it.
interface vscale_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_resp_valid;
  logic [DATA_WIDTH-1:0] imem_resp_rdata;
  logic                  imem_badmem_e;

  logic                  dmem_req_valid;
  logic                  dmem_req_ready;
  logic [ADDR_WIDTH-1:0] dmem_req_addr;
  logic                  dmem_req_wen;
  logic [2:0]            dmem_req_size;
  logic [DATA_WIDTH-1:0] dmem_req_wdata;
  logic                  dmem_resp_valid;
  logic [DATA_WIDTH-1:0] dmem_resp_rdata;
  logic                  dmem_badmem_e;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_wen;
  logic [2:0]            mem_req_size;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_rdata;
  logic                  mem_resp_err;

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_rdata, imem_badmem_e,
    input  dmem_req_valid, dmem_req_addr, dmem_req_wen, dmem_req_size, dmem_req_wdata,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata, dmem_badmem_e,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_size, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_rdata, imem_badmem_e,
    output dmem_req_valid, dmem_req_addr, dmem_req_wen, dmem_req_size, dmem_req_wdata,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata, dmem_badmem_e,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_size, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );

endinterface

// File: rtl/vscale_mem_arb_timeout.sv
// Loadable saturating down-counter: clear loads LIMIT, en decrements, expired when it reads zero.
// expired is a plain decode of the count register; no backpressure.
module vscale_mem_arb_timeout
  import vscale_mem_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_W-1:0] LOAD_VAL = TMO_W'(LIMIT);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - TMO_W'(1);
    end
  end

  assign expired = (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vscale_mem_arbiter.sv
// Shares one memory port between imem and dmem, one transaction in flight; accept->mem_req_valid 1 cycle,
// response forwarded combinationally; requests are held off (ready low) until the current one completes.
module vscale_mem_arbiter
  import vscale_mem_arbiter_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  vscale_mem_arbiter_if.slave   bus
);

  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [2:0]            size_q, size_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  grant_imem;
  logic                  grant_dmem;
  logic                  imem_rdy;
  logic                  dmem_rdy;
  logic                  mem_vld;
  logic                  tmo_clear;
  logic                  tmo_en;
  logic                  tmo_expired;
  logic                  resp_fire;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  fire_imem;
  logic                  fire_dmem;

  // On a tie the side that did not win last time gets the port.
  assign grant_dmem = bus.dmem_req_valid && (!bus.imem_req_valid || (last_grant_q == OWNER_IMEM));
  assign grant_imem = bus.imem_req_valid && !grant_dmem;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    imem_rdy     = 1'b0;
    dmem_rdy     = 1'b0;
    mem_vld      = 1'b0;
    tmo_clear    = 1'b0;
    tmo_en       = 1'b0;
    resp_fire    = 1'b0;
    resp_err     = 1'b0;
    resp_data    = '0;

    case (state_q)
      ST_IDLE: begin
        imem_rdy = grant_imem;
        dmem_rdy = grant_dmem;
        if (grant_dmem) begin
          owner_d      = OWNER_DMEM;
          last_grant_d = OWNER_DMEM;
          addr_d       = bus.dmem_req_addr;
          wen_d        = bus.dmem_req_wen;
          size_d       = bus.dmem_req_size;
          wdata_d      = bus.dmem_req_wdata;
          state_d      = dmem_misaligned(bus.dmem_req_size, bus.dmem_req_addr[1:0]) ? ST_ERR : ST_REQ;
        end else if (grant_imem) begin
          owner_d      = OWNER_IMEM;
          last_grant_d = OWNER_IMEM;
          addr_d       = bus.imem_req_addr;
          wen_d        = 1'b0;
          size_d       = MEM_SIZE_WORD;
          wdata_d      = '0;
          state_d      = (bus.imem_req_addr[1:0] != 2'b00) ? ST_ERR : ST_REQ;
        end
      end

      ST_REQ: begin
        mem_vld = 1'b1;
        if (bus.mem_req_ready) begin
          tmo_clear = 1'b1;
          state_d   = ST_RESP;
        end
      end

      // A real response takes priority over a timeout landing in the same cycle.
      ST_RESP: begin
        if (bus.mem_resp_valid) begin
          resp_fire = 1'b1;
          resp_err  = bus.mem_resp_err;
          resp_data = bus.mem_resp_rdata;
          state_d   = ST_IDLE;
        end else if (tmo_expired) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
          state_d   = ST_DRAIN;
        end else begin
          tmo_en = 1'b1;
        end
      end

      ST_ERR: begin
        resp_fire = 1'b1;
        resp_err  = 1'b1;
        state_d   = ST_IDLE;
      end

      // The timed-out response is still owed by memory; swallow it before reusing the port.
      ST_DRAIN: begin
        if (bus.mem_resp_valid) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_IMEM;
      last_grant_q <= OWNER_IMEM;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      size_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
    end
  end

  vscale_mem_arb_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  assign fire_imem = resp_fire && (owner_q == OWNER_IMEM);
  assign fire_dmem = resp_fire && (owner_q == OWNER_DMEM);

  assign bus.imem_req_ready  = imem_rdy;
  assign bus.dmem_req_ready  = dmem_rdy;

  assign bus.mem_req_valid   = mem_vld;
  assign bus.mem_req_addr    = addr_q;
  assign bus.mem_req_wen     = wen_q;
  assign bus.mem_req_size    = size_q;
  assign bus.mem_req_wdata   = wdata_q;

  assign bus.imem_resp_valid = fire_imem;
  assign bus.imem_resp_rdata = fire_imem ? resp_data : '0;
  assign bus.imem_badmem_e   = fire_imem && resp_err;

  assign bus.dmem_resp_valid = fire_dmem;
  assign bus.dmem_resp_rdata = fire_dmem ? resp_data : '0;
  assign bus.dmem_badmem_e   = fire_dmem && resp_err;

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Directed bench for vscale_mem_arbiter with a response scoreboard; TIMEOUT_CYCLES is 4.
module tb_vscale_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;
  exp_t sb[$];

  // error-path cases: side, address, size, write enable
  logic        er_d  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [31:0] er_a  [4] = '{32'h203, 32'h102, 32'h300, 32'h202};
  logic [2:0]  er_s  [4] = '{3'd1, 3'd2, 3'd3, 3'd2};
  logic        er_w  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  vscale_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vscale_mem_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic d, input logic [31:0] data, input logic err);
    exp_t e;
    e.is_d = d;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  // Sample at the falling edge; any response pulse must match the oldest expectation.
  task automatic mon();
    exp_t e;
    @(negedge clk);
    if (bus.imem_resp_valid || bus.dmem_resp_valid) begin
      check("resp_dual", bus.imem_resp_valid & bus.dmem_resp_valid, 0);
      if (sb.size() == 0) begin
        check("resp_spurious", {bus.imem_resp_valid, bus.dmem_resp_valid}, 0);
      end else begin
        e = sb.pop_front();
        check("resp_owner", bus.dmem_resp_valid, e.is_d);
        check("resp_rdata", e.is_d ? bus.dmem_resp_rdata : bus.imem_resp_rdata, e.data);
        check("resp_err", e.is_d ? bus.dmem_badmem_e : bus.imem_badmem_e, e.err);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic d, input logic [31:0] a, input logic wen,
                         input logic [2:0] sz, input logic [31:0] wd);
    if (d) begin
      bus.dmem_req_valid = 1'b1;
      bus.dmem_req_addr  = a;
      bus.dmem_req_wen   = wen;
      bus.dmem_req_size  = sz;
      bus.dmem_req_wdata = wd;
    end else begin
      bus.imem_req_valid = 1'b1;
      bus.imem_req_addr  = a;
    end
  endtask

  task automatic drop_req();
    bus.imem_req_valid = 1'b0;
    bus.dmem_req_valid = 1'b0;
  endtask

  task automatic set_resp(input logic v, input logic [31:0] rd, input logic err);
    bus.mem_resp_valid = v;
    bus.mem_resp_rdata = rd;
    bus.mem_resp_err   = err;
  endtask

  // Minimum-latency transaction: accept c0, request c1, response c2, idle again at c3.
  task automatic txn(input logic d, input logic [31:0] a, input logic wen, input logic [2:0] sz,
                     input logic [31:0] wd, input logic [31:0] rd, input logic err);
    set_req(d, a, wen, sz, wd);
    bus.mem_req_ready = 1'b1;
    push_exp(d, rd, err);
    mon();
    check("txn_acc", d ? bus.dmem_req_ready : bus.imem_req_ready, 1);
    check("txn_mrv0", bus.mem_req_valid, 0);
    adv();
    drop_req();
    mon();
    check("txn_mrv1", bus.mem_req_valid, 1);
    check("txn_addr", bus.mem_req_addr, a);
    check("txn_wen", bus.mem_req_wen, d ? wen : 1'b0);
    check("txn_size", bus.mem_req_size, d ? sz : 3'd2);
    if (d && wen) check("txn_wdata", bus.mem_req_wdata, wd);
    adv();
    set_resp(1'b1, rd, err);
    mon();
    check("txn_resp_cyc", d ? bus.dmem_resp_valid : bus.imem_resp_valid, 1);
    adv();
    set_resp(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    drop_req();
    bus.imem_req_addr  = '0;
    bus.dmem_req_addr  = '0;
    bus.dmem_req_wen   = 1'b0;
    bus.dmem_req_size  = 3'd0;
    bus.dmem_req_wdata = '0;
    bus.mem_req_ready  = 1'b0;
    set_resp(1'b0, 32'h0, 1'b0);

    // reset state
    @(negedge clk);
    check("rst_mem_vld", bus.mem_req_valid, 0);
    check("rst_mem_addr", bus.mem_req_addr, 0);
    check("rst_mem_size", bus.mem_req_size, 0);
    check("rst_iresp", bus.imem_resp_valid, 0);
    check("rst_dresp", bus.dmem_resp_valid, 0);
    check("rst_irdy_idle", bus.imem_req_ready, 0);
    bus.imem_req_valid = 1'b1;
    #1;
    check("rst_irdy_arb", bus.imem_req_ready, 1);
    bus.dmem_req_valid = 1'b1;
    #1;
    check("rst_tie_d", bus.dmem_req_ready, 1);
    check("rst_tie_i", bus.imem_req_ready, 0);
    drop_req();
    adv();
    reset = 1'b1;

    // round-robin tie: dmem, imem, dmem, imem
    set_req(1'b0, 32'h400, 1'b0, 3'd2, 32'h0);
    set_req(1'b1, 32'h500, 1'b0, 3'd2, 32'h0);
    bus.mem_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic        exp_d;
      logic [31:0] rd;
      exp_d = (k % 2 == 0);
      rd    = 32'h1000 + 32'(k);
      mon();
      check("rr_grant_d", bus.dmem_req_ready, exp_d);
      check("rr_grant_i", bus.imem_req_ready, !exp_d);
      push_exp(exp_d, rd, 1'b0);
      adv();
      mon();
      check("rr_addr", bus.mem_req_addr, exp_d ? 32'h500 : 32'h400);
      check("rr_busy_rdy", bus.imem_req_ready | bus.dmem_req_ready, 0);
      adv();
      set_resp(1'b1, rd, 1'b0);
      mon();
      adv();
      set_resp(1'b0, 32'h0, 1'b0);
    end
    drop_req();

    // normal transactions
    txn(1'b0, 32'h100, 1'b0, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0);
    txn(1'b1, 32'h204, 1'b1, 3'd2, 32'h11223344, 32'h0, 1'b0);
    txn(1'b1, 32'h203, 1'b0, 3'd0, 32'h0, 32'h000000AB, 1'b0);
    txn(1'b1, 32'h202, 1'b1, 3'd1, 32'h0000BEEF, 32'h0, 1'b0);
    txn(1'b1, 32'h300, 1'b0, 3'd2, 32'h0, 32'h5555AAAA, 1'b1);

    // error path, back to back: accept c0, error pulse c1, next accept c2
    for (int i = 0; i < 4; i++) begin
      set_req(er_d[i], er_a[i], er_w[i], er_s[i], 32'hFFFF0000);
      push_exp(er_d[i], 32'h0, 1'b1);
      mon();
      check("err_acc", er_d[i] ? bus.dmem_req_ready : bus.imem_req_ready, 1);
      adv();
      drop_req();
      mon();
      check("err_resp_cyc", er_d[i] ? bus.dmem_resp_valid : bus.imem_resp_valid, 1);
      check("err_no_mem", bus.mem_req_valid, 0);
      adv();
    end

    // timeout, then late response drained before the next grant
    set_req(1'b1, 32'h600, 1'b0, 3'd2, 32'h0);
    push_exp(1'b1, 32'h0, 1'b1);
    mon();
    check("tmo_acc", bus.dmem_req_ready, 1);
    adv();
    drop_req();
    mon();
    check("tmo_mrv", bus.mem_req_valid, 1);
    adv();
    for (int k = 0; k < TMO; k++) begin
      mon();
      check("tmo_wait", bus.dmem_resp_valid, 0);
      adv();
    end
    mon();
    check("tmo_fire", bus.dmem_resp_valid, 1);
    adv();
    set_req(1'b0, 32'h104, 1'b0, 3'd2, 32'h0);
    for (int k = 0; k < 10; k++) begin
      mon();
      check("drain_block", bus.imem_req_ready, 0);
      adv();
    end
    set_resp(1'b1, 32'h00000BAD, 1'b0);
    mon();
    check("drain_late_block", bus.imem_req_ready, 0);
    adv();
    set_resp(1'b0, 32'h0, 1'b0);
    push_exp(1'b0, 32'hCAFEF00D, 1'b0);
    mon();
    check("post_drain_acc", bus.imem_req_ready, 1);
    adv();
    drop_req();
    mon();
    check("post_drain_addr", bus.mem_req_addr, 32'h104);
    adv();
    set_resp(1'b1, 32'hCAFEF00D, 1'b0);
    mon();
    adv();
    set_resp(1'b0, 32'h0, 1'b0);

    // response arriving on the expiry cycle wins and returns to IDLE
    set_req(1'b1, 32'h608, 1'b0, 3'd2, 32'h0);
    push_exp(1'b1, 32'h00000077, 1'b0);
    mon();
    adv();
    drop_req();
    mon();
    adv();
    for (int k = 0; k < TMO; k++) begin
      mon();
      check("tie_wait", bus.dmem_resp_valid, 0);
      adv();
    end
    set_resp(1'b1, 32'h00000077, 1'b0);
    mon();
    check("tie_real", bus.dmem_resp_valid, 1);
    adv();
    set_resp(1'b0, 32'h0, 1'b0);
    txn(1'b1, 32'h60C, 1'b0, 3'd2, 32'h0, 32'h13572468, 1'b0);

    // reset while the request is stalled in REQ
    set_req(1'b0, 32'h700, 1'b0, 3'd2, 32'h0);
    bus.mem_req_ready = 1'b0;
    mon();
    check("rmid_acc", bus.imem_req_ready, 1);
    adv();
    drop_req();
    mon();
    check("rmid_mrv", bus.mem_req_valid, 1);
    adv();
    mon();
    check("rmid_hold", bus.mem_req_valid, 1);
    check("rmid_hold_addr", bus.mem_req_addr, 32'h700);
    #2;
    reset = 1'b0;
    #1;
    check("rmid_async_mrv", bus.mem_req_valid, 0);
    check("rmid_async_addr", bus.mem_req_addr, 0);
    adv();
    reset = 1'b1;
    txn(1'b0, 32'h800, 1'b0, 3'd2, 32'h0, 32'h12121212, 1'b0);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
